enemy_wave: RTL
===============

// Module: enemy_wave
// PURPOSE
//  Parametrised enemy formation for Warblade: N_EN enemies drawn on the VGA timing stream in one row, offset from a
//  formation origin (from main_gen). Adds per-enemy hit points, a wave FSM with level-up, and a round-robin enemy
//  fire scheduler with a valid/ready handshake to the enemy-missile launcher. Sits between background and player.
// PARAMETERS
//  N_EN         5       enemies in formation (1..16)
//  SPACING_X    96      x pitch between enemies, pixels
//  EN_W / EN_H  32/32   enemy box size, pixels
//  HP           1       hits needed per enemy (1..3)
//  COLOR        12'hF00 enemy pixel colour
//  CLEAR_FRAMES 60      frames between wave cleared and respawn
//  FIRE_PERIOD  30      frames between fire requests
//  MAX_LEVEL    9       level saturation value
// PORTS
//  pclk          in   1      pixel clock
//  rst           in   1      async reset, active-low
//  vcount_in/hcount_in in 11 timing counters;  vsync_in/vblnk_in/hsync_in/hblnk_in in 1; rgb_in in 12
//  x_base,y_base in   11     formation origin
//  xpos_missile,ypos_missile in 11 player missile tip;  on_missile in 1 player missile in flight
//  vcount_out/hcount_out out 11; vsync_out/vblnk_out/hsync_out/hblnk_out out 1; rgb_out out 12
//  missile_hit   out  1      1-cycle pulse: player missile struck an enemy
//  alive         out  N_EN   alive mask, bit i = enemy i
//  shot_valid    out  1      fire request;  shot_x,shot_y out 11 launch point;  shot_ready in 1 launcher accepts
//  level_out     out  4      current level;  level_up out 1 1-cycle pulse
// BEHAVIOUR
//  Reset: all timing outs, rgb_out, missile_hit, shot_*, level_up = 0; alive = 0; level_out = 1; state SPAWN;
//   fire ptr = N_EN-1; frame counters 0; hit lockout clear.
//  Geometry: enemy i box x in [x_base+i*SPACING_X, +EN_W), y in [y_base, +EN_H); 12-bit sums, bit 11 set = off-screen.
//  Video: 2-cycle latency for every timing signal and rgb. rgb_out = COLOR if delayed pixel is in an alive box and
//   state != CLEARED, else delayed rgb_in.
//  Frame tick: rising edge of vsync_in (registered detect).
//  FSM: SPAWN (1 cycle: alive = all ones, hp[i] = HP) -> ACTIVE; ACTIVE -> CLEARED when alive == 0;
//   CLEARED counts CLEAR_FRAMES ticks -> LEVEL_UP (1 cycle: level = min(level+1, MAX_LEVEL), level_up = 1) -> SPAWN.
//  Hit: in ACTIVE, on_missile && tip inside alive box && lockout clear -> lowest index i hit: hp[i]--, on 0 alive[i] = 0;
//   missile_hit pulses 1 cycle at the next edge; lockout set until on_missile deasserts. Lockout makes one hit per flight.
//  Fire: in ACTIVE, on each FIRE_PERIOD-th tick with shot_valid low: search from ptr+1 (wraps) for first enemy alive
//   in alive_next; found -> ptr = i, shot_valid = 1, shot_x = box_x+EN_W/2, shot_y = y_base+EN_H. None alive -> no request.
//   The period counter still advances while a request is pending; a period that elapses then is dropped.
//  Handshake: shot_valid/x/y held stable until shot_valid&&shot_ready edge, then shot_valid = 0 next cycle.
//   A shooter killed or a wave cleared while pending does not withdraw it; only reset does.
//  Same-cycle hit on enemy i and fire selection: i is skipped (selection uses alive_next).
//  Reset mid-operation: asynchronous; all state returns to reset values immediately.
// STRUCTURE
//  Package enemy_defs: wave state encoding (SPAWN/ACTIVE/CLEARED/LEVEL_UP), COORD_W=11, RGB_W=12, LEVEL_W=4.
//  Sub-module enemy_slot (generate x N_EN): box compare for pixel and missile, hp counter, alive bit.
//  Top: timing pipeline, priority hit arbiter, FSM, frame counters, fire scheduler.
// TESTING
//  1 Release reset, x_base=100, y_base=50 -> after SPAWN alive=5'b11111; pixel (292,50) -> rgb_out=12'hF00 2 cycles later.
//  2 HP=1, missile (110,60) with on_missile held 10 cycles -> exactly one missile_hit pulse, alive=5'b11110, (100,50) passes rgb_in.
//  3 HP=2, two separate flights at (110,60) -> alive[0] clears only after the 2nd; 2 missile_hit pulses.
//  4 Kill all 5, CLEAR_FRAMES=2 -> 2 vsync edges, level_up pulse, level 1->2, alive=5'b11111; at level 9 it stays 9.
//  5 FIRE_PERIOD=1, shot_ready=0 -> shot_valid=1, (116,82) stable for 5 frames; ready 1 cycle -> next frame (212,82) from enemy 1.
//  6 Assert rst during ACTIVE with shot_valid=1 -> all outputs 0 / level_out=1 without waiting for a pclk edge.

Source files
------------

// File: rtl/enemy_defs.sv
// Shared definitions for the enemy formation block.
//   COORD_W / RGB_W / LEVEL_W : screen coordinate, colour and level widths
//   wave_state_e              : wave FSM encoding
//   in_range()                : 1-D box test with off-screen origin rejection
package enemy_defs;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned LEVEL_W = 4;

  typedef enum logic [1:0] {
    StSpawn   = 2'd0,
    StActive  = 2'd1,
    StCleared = 2'd2,
    StLevelUp = 2'd3
  } wave_state_e;

  // True when p lies in [lo, lo+len). lo carries one extra bit; when that bit
  // is set the box origin has wrapped off-screen and nothing can match.
  function automatic logic in_range(input logic [COORD_W-1:0] p,
                                    input logic [COORD_W:0]   lo,
                                    input int unsigned        len);
    logic [COORD_W:0] d;
    d = {1'b0, p} - lo;
    return !lo[COORD_W] && ({1'b0, p} >= lo) && (32'(d) < len);
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy of the formation: box geometry, hit points and alive bit.
//   pclk, rst          : pixel clock, async active-low reset
//   x_base, y_base     : formation origin
//   hcount, vcount     : current pixel
//   xpos/ypos_missile  : player missile tip
//   spawn              : reload hit points and revive
//   hit                : this enemy was selected by the hit arbiter
//   fire_x             : horizontal launch point (box centre)
//   pix_in, mis_in     : pixel / missile tip inside this box while alive
//   alive, alive_next  : current alive bit and its value after this cycle
module enemy_slot
  import enemy_defs::*;
#(
  parameter int unsigned IDX       = 0,
  parameter int unsigned SPACING_X = 96,
  parameter int unsigned EN_W      = 32,
  parameter int unsigned EN_H      = 32,
  parameter int unsigned HP        = 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_base,
  input  logic [COORD_W-1:0] y_base,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] xpos_missile,
  input  logic [COORD_W-1:0] ypos_missile,
  input  logic               spawn,
  input  logic               hit,
  output logic [COORD_W-1:0] fire_x,
  output logic               pix_in,
  output logic               mis_in,
  output logic               alive,
  output logic               alive_next
);

  localparam int unsigned BW = COORD_W + 1;

  logic [BW-1:0] box_x, box_y;
  logic [1:0]    hp_q, hp_d;
  logic          alive_q, alive_d;

  assign box_x  = {1'b0, x_base} + BW'(IDX * SPACING_X);
  assign box_y  = {1'b0, y_base};
  assign fire_x = box_x[COORD_W-1:0] + COORD_W'(EN_W / 2);

  assign pix_in = alive_q && in_range(hcount, box_x, EN_W) && in_range(vcount, box_y, EN_H);
  assign mis_in = alive_q && in_range(xpos_missile, box_x, EN_W)
                  && in_range(ypos_missile, box_y, EN_H);

  always_comb begin
    hp_d    = hp_q;
    alive_d = alive_q;
    if (spawn) begin
      hp_d    = 2'(HP);
      alive_d = 1'b1;
    end else if (hit && alive_q) begin
      hp_d = hp_q - 2'd1;
      if (hp_q == 2'd1) alive_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hp_q    <= 2'd0;
      alive_q <= 1'b0;
    end else begin
      hp_q    <= hp_d;
      alive_q <= alive_d;
    end
  end

  assign alive      = alive_q;
  assign alive_next = alive_d;

endmodule

// File: rtl/enemy_wave.sv
// Enemy formation: draws N_EN enemies on the video stream (2-cycle latency),
// resolves player missile hits, runs the wave/level FSM and schedules enemy
// fire round-robin towards the missile launcher over a valid/ready handshake.
//   pclk, rst                     : pixel clock, async active-low reset
//   *_in / *_out                  : video timing and colour, in and delayed
//   x_base, y_base                : formation origin
//   xpos/ypos_missile, on_missile : player missile tip and in-flight flag
//   missile_hit                   : 1-cycle pulse per hit
//   alive                         : alive mask
//   shot_valid/x/y, shot_ready    : enemy fire request handshake
//   level_out, level_up           : current level and level-up pulse
module enemy_wave
  import enemy_defs::*;
#(
  parameter int unsigned       N_EN         = 5,
  parameter int unsigned       SPACING_X    = 96,
  parameter int unsigned       EN_W         = 32,
  parameter int unsigned       EN_H         = 32,
  parameter int unsigned       HP           = 1,
  parameter logic [RGB_W-1:0]  COLOR        = 12'hF00,
  parameter int unsigned       CLEAR_FRAMES = 60,
  parameter int unsigned       FIRE_PERIOD  = 30,
  parameter int unsigned       MAX_LEVEL    = 9
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [COORD_W-1:0] x_base,
  input  logic [COORD_W-1:0] y_base,
  input  logic [COORD_W-1:0] xpos_missile,
  input  logic [COORD_W-1:0] ypos_missile,
  input  logic               on_missile,
  output logic [COORD_W-1:0] vcount_out,
  output logic [COORD_W-1:0] hcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               missile_hit,
  output logic [N_EN-1:0]    alive,
  output logic               shot_valid,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  input  logic               shot_ready,
  output logic [LEVEL_W-1:0] level_out,
  output logic               level_up
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PTR_W = (N_EN > 1) ? $clog2(N_EN) : 1;

  wave_state_e state_q, state_d;

  logic [N_EN-1:0]    pix_vec, mis_vec, alive_vec, alive_nx, hit_vec;
  logic [COORD_W-1:0] fire_x [N_EN];
  logic               spawn, hit_any, hit_found, tick, vsync_q;
  logic               lockout_q, missile_hit_q;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d, fire_cnt_q, fire_cnt_d;
  logic               clr_done, fire_due;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, sel_idx;
  logic               sel_found;
  logic [COORD_W-1:0] sel_x;
  logic               shot_valid_q, shot_valid_d;
  logic [COORD_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;

  logic [COORD_W-1:0] vcount_q1, hcount_q1;
  logic [3:0]         sync_q1;
  logic [RGB_W-1:0]   rgb_q1;
  logic               pix_q1;

  for (genvar i = 0; i < N_EN; i++) begin : g_slot
    enemy_slot #(
      .IDX       (i),
      .SPACING_X (SPACING_X),
      .EN_W      (EN_W),
      .EN_H      (EN_H),
      .HP        (HP)
    ) u_slot (
      .pclk         (pclk),
      .rst          (rst),
      .x_base       (x_base),
      .y_base       (y_base),
      .hcount       (hcount_in),
      .vcount       (vcount_in),
      .xpos_missile (xpos_missile),
      .ypos_missile (ypos_missile),
      .spawn        (spawn),
      .hit          (hit_vec[i]),
      .fire_x       (fire_x[i]),
      .pix_in       (pix_vec[i]),
      .mis_in       (mis_vec[i]),
      .alive        (alive_vec[i]),
      .alive_next   (alive_nx[i])
    );
  end

  // Video pipeline: stage 1 latches the box test, stage 2 muxes the colour.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vcount_q1  <= '0;
      hcount_q1  <= '0;
      sync_q1    <= '0;
      rgb_q1     <= '0;
      pix_q1     <= 1'b0;
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_q1  <= vcount_in;
      hcount_q1  <= hcount_in;
      sync_q1    <= {vsync_in, vblnk_in, hsync_in, hblnk_in};
      rgb_q1     <= rgb_in;
      pix_q1     <= |pix_vec;
      vcount_out <= vcount_q1;
      hcount_out <= hcount_q1;
      {vsync_out, vblnk_out, hsync_out, hblnk_out} <= sync_q1;
      rgb_out    <= (pix_q1 && state_q != StCleared) ? COLOR : rgb_q1;
    end
  end

  assign tick = vsync_in && !vsync_q;

  // Lowest-index enemy under the missile tip wins; one hit per flight.
  always_comb begin
    hit_vec   = '0;
    hit_found = 1'b0;
    if (state_q == StActive && on_missile && !lockout_q) begin
      for (int i = 0; i < N_EN; i++) begin
        if (!hit_found && mis_vec[i]) begin
          hit_vec[i] = 1'b1;
          hit_found  = 1'b1;
        end
      end
    end
  end

  assign hit_any = |hit_vec;

  // Wave FSM: next state.
  assign clr_done = (state_q == StCleared) && tick && (clr_cnt_q == CNT_W'(CLEAR_FRAMES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSpawn:   state_d = StActive;
      StActive:  if (alive_vec == '0) state_d = StCleared;
      StCleared: if (clr_done) state_d = StLevelUp;
      StLevelUp: state_d = StSpawn;
      default:   state_d = StSpawn;
    endcase
  end

  // Wave FSM: outputs.
  always_comb begin
    spawn    = (state_q == StSpawn);
    level_up = (state_q == StLevelUp);
  end

  always_comb begin
    clr_cnt_d = '0;
    if (state_q == StCleared && tick) clr_cnt_d = clr_cnt_q + CNT_W'(1);
    else if (state_q == StCleared)    clr_cnt_d = clr_cnt_q;

    level_d = level_q;
    if (state_q == StLevelUp && level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + 4'd1;
  end

  // Fire period keeps running while a request is pending; that period is lost.
  assign fire_due = (state_q == StActive) && tick && (fire_cnt_q == CNT_W'(FIRE_PERIOD - 1));

  always_comb begin
    fire_cnt_d = '0;
    if (state_q == StActive) begin
      if (fire_due)  fire_cnt_d = '0;
      else if (tick) fire_cnt_d = fire_cnt_q + CNT_W'(1);
      else           fire_cnt_d = fire_cnt_q;
    end
  end

  // Round-robin pick starting after ptr; alive_next excludes an enemy dying now.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    sel_x     = '0;
    for (int i = 0; i < N_EN; i++) begin
      if (!sel_found && i > int'(ptr_q) && alive_nx[i]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(i);
        sel_x     = fire_x[i];
      end
    end
    for (int i = 0; i < N_EN; i++) begin
      if (!sel_found && i <= int'(ptr_q) && alive_nx[i]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(i);
        sel_x     = fire_x[i];
      end
    end
  end

  always_comb begin
    shot_valid_d = shot_valid_q;
    shot_x_d     = shot_x_q;
    shot_y_d     = shot_y_q;
    ptr_d        = ptr_q;
    if (shot_valid_q) begin
      if (shot_ready) shot_valid_d = 1'b0;
    end else if (fire_due && sel_found) begin
      shot_valid_d = 1'b1;
      shot_x_d     = sel_x;
      shot_y_d     = y_base + COORD_W'(EN_H);
      ptr_d        = sel_idx;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= StSpawn;
      vsync_q       <= 1'b0;
      lockout_q     <= 1'b0;
      missile_hit_q <= 1'b0;
      clr_cnt_q     <= '0;
      fire_cnt_q    <= '0;
      level_q       <= LEVEL_W'(1);
      ptr_q         <= PTR_W'(N_EN - 1);
      shot_valid_q  <= 1'b0;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_in;
      missile_hit_q <= hit_any;
      if (!on_missile)  lockout_q <= 1'b0;
      else if (hit_any) lockout_q <= 1'b1;
      clr_cnt_q     <= clr_cnt_d;
      fire_cnt_q    <= fire_cnt_d;
      level_q       <= level_d;
      ptr_q         <= ptr_d;
      shot_valid_q  <= shot_valid_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
    end
  end

  assign missile_hit = missile_hit_q;
  assign alive       = alive_vec;
  assign level_out   = level_q;
  assign shot_valid  = shot_valid_q;
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;

endmodule
